exit_terminal: RTL and testbench

- Keypad-side exit terminal that acts as the initiator of the parking controller's exit protocol.
- Collects a spot digit and a two-nibble passcode from the keypad, then issues a one-cycle car_exit request with exit_from/exit_code.
- Waits for the controller's verdict, opens the gate on success, and enforces a lockout after repeated failures.
- Sits between the keypad scanner and car_parking.

---
 rtl/car_park_pkg.sv | 42 ++++
 rtl/exit_terminal_if.sv | 40 ++++
 rtl/exit_terminal_timer.sv | 33 +++
 rtl/exit_terminal.sv | 185 ++++++++++++++++++
 tb/tb_exit_terminal.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_park_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : car_park_pkg
// Description : Shared types and constants for the car park exit path.
// Revision    : 1.0 - initial release
// ============================================================================
package car_park_pkg;

    localparam int c_SPOT_W = 3;
    localparam int c_CODE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CODE_HI   = 3'd1,
        CODE_LO   = 3'd2,
        REQ       = 3'd3,
        WAIT_RESP = 3'd4,
        OPEN      = 3'd5,
        DENY      = 3'd6,
        LOCKOUT   = 3'd7
    } state_t;

    // Controller passcode for each spot: Fibonacci partial sums.
    function automatic logic [c_CODE_W-1:0] pass_code(input logic [c_SPOT_W-1:0] spot);
        logic [c_CODE_W-1:0] code;
        code = '0;
        case (spot)
            3'd1:    code = 8'h03;
            3'd2:    code = 8'h06;
            3'd3:    code = 8'h0B;
            3'd4:    code = 8'h13;
            3'd5:    code = 8'h20;
            3'd6:    code = 8'h35;
            3'd7:    code = 8'h57;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exit_terminal_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exit_terminal_if
// Description : Keypad, controller handshake and status signals of the
//               exit terminal. master = terminal side.
// Revision    : 1.0 - initial release
// ============================================================================
interface exit_terminal_if;

    logic                            key_valid;
    logic [3:0]                      key_data;
    logic                            key_cancel;
    logic                            car_exit;
    logic [car_park_pkg::c_SPOT_W-1:0] exit_from;
    logic [car_park_pkg::c_CODE_W-1:0] exit_code;
    logic                            resp_ok;
    logic                            resp_fail;
    logic                            gate_open;
    logic                            deny_led;
    logic                            key_error;
    logic                            timeout;
    logic                            locked;
    logic [2:0]                      fail_count;
    logic                            busy;

    modport master (
        input  key_valid, key_data, key_cancel, resp_ok, resp_fail,
        output car_exit, exit_from, exit_code, gate_open, deny_led,
               key_error, timeout, locked, fail_count, busy
    );

    modport slave (
        output key_valid, key_data, key_cancel, resp_ok, resp_fail,
        input  car_exit, exit_from, exit_code, gate_open, deny_led,
               key_error, timeout, locked, fail_count, busy
    );

endinterface
`default_nettype wire

// File: rtl/exit_terminal_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ex_timer
// Description : Loadable down-counter that holds at zero; done while zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_timer #(
    parameter int WIDTH = 7
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    output logic                  o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/exit_terminal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : exit_terminal
// Description : Keypad exit terminal: collects spot and passcode, requests
//               exit from the controller, opens the gate or counts failures.
// Revision    : 1.0 - initial release
// ============================================================================
module exit_terminal
    import car_park_pkg::*;
#(
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 64,
    parameter int GATE_CYCLES = 8,
    parameter int TIMEOUT     = 16
) (
    input  wire logic       enable,
    input  wire logic       gl_reset,
    exit_terminal_if.master bus
);

    localparam int c_TMR_MAX =
        (TIMEOUT > GATE_CYCLES) ?
            ((TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES) :
            ((GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES);
    localparam int c_TMR_W = $clog2(c_TMR_MAX) + 1;

    // Timer is loaded with duration-1 on entry; state exits when it reads zero.
    localparam logic [c_TMR_W-1:0] c_WAIT_LOAD = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_GATE_LOAD = c_TMR_W'(GATE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LOCK_LOAD = c_TMR_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]         c_MAX_FC    = 3'(MAX_TRIES);

    state_t                r_state;
    state_t                w_next;
    logic [c_SPOT_W-1:0]   r_exit_from;
    logic [c_CODE_W-1:0]   r_exit_code;
    logic [2:0]            r_fail_count;
    logic [2:0]            w_fc_next;
    logic [2:0]            w_fc_inc;
    logic                  r_key_error;
    logic                  r_timeout;
    logic                  w_timed_out;
    logic                  w_tmr_load;
    logic [c_TMR_W-1:0]    w_tmr_val;
    logic                  w_tmr_done;
    logic                  w_entry;
    logic                  w_cancel;
    logic                  w_key;
    logic                  w_spot_ok;

    assign w_entry   = (r_state == IDLE) || (r_state == CODE_HI) || (r_state == CODE_LO);
    assign w_cancel  = w_entry && bus.key_cancel;
    assign w_key     = w_entry && bus.key_valid && !bus.key_cancel;
    assign w_spot_ok = (bus.key_data[3] == 1'b0) && (bus.key_data[2:0] != 3'd0);
    assign w_fc_inc  = (r_fail_count < c_MAX_FC) ? (r_fail_count + 3'd1) : r_fail_count;

    ex_timer #(
        .WIDTH      (c_TMR_W)
    ) u_timer (
        .clk        (enable),
        .rst        (gl_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge enable) begin
        if (gl_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_fc_next   = r_fail_count;
        w_timed_out = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_key && w_spot_ok) begin
                    w_next = CODE_HI;
                end
            end
            CODE_HI: begin
                if (w_cancel) begin
                    w_next = IDLE;
                end else if (w_key) begin
                    w_next = CODE_LO;
                end
            end
            CODE_LO: begin
                if (w_cancel) begin
                    w_next = IDLE;
                end else if (w_key) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                w_next     = WAIT_RESP;
                w_tmr_load = 1'b1;
                w_tmr_val  = c_WAIT_LOAD;
            end
            WAIT_RESP: begin
                // A fail verdict overrides a simultaneous ok.
                if (bus.resp_fail) begin
                    w_next    = DENY;
                    w_fc_next = w_fc_inc;
                end else if (bus.resp_ok) begin
                    w_next     = OPEN;
                    w_fc_next  = 3'd0;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_GATE_LOAD;
                end else if (w_tmr_done) begin
                    w_next      = DENY;
                    w_fc_next   = w_fc_inc;
                    w_timed_out = 1'b1;
                end
            end
            OPEN: begin
                if (w_tmr_done) begin
                    w_next = IDLE;
                end
            end
            DENY: begin
                if (r_fail_count == c_MAX_FC) begin
                    w_next     = LOCKOUT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_LOCK_LOAD;
                end else begin
                    w_next = IDLE;
                end
            end
            LOCKOUT: begin
                if (w_tmr_done) begin
                    w_next    = IDLE;
                    w_fc_next = 3'd0;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge enable) begin
        if (gl_reset) begin
            r_exit_from  <= '0;
            r_exit_code  <= '0;
            r_fail_count <= '0;
            r_key_error  <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_fail_count <= w_fc_next;
            r_timeout    <= w_timed_out;
            r_key_error  <= w_key && (r_state == IDLE) && !w_spot_ok;
            if (w_key && (r_state == IDLE) && w_spot_ok) begin
                r_exit_from <= bus.key_data[c_SPOT_W-1:0];
            end
            if (w_cancel) begin
                r_exit_code <= '0;
            end else if (w_key && (r_state == CODE_HI)) begin
                r_exit_code[7:4] <= bus.key_data;
            end else if (w_key && (r_state == CODE_LO)) begin
                r_exit_code[3:0] <= bus.key_data;
            end
        end
    end

    assign bus.car_exit   = (r_state == REQ);
    assign bus.exit_from  = r_exit_from;
    assign bus.exit_code  = r_exit_code;
    assign bus.gate_open  = (r_state == OPEN);
    assign bus.deny_led   = (r_state == DENY);
    assign bus.key_error  = r_key_error;
    assign bus.timeout    = r_timeout;
    assign bus.locked     = (r_state == LOCKOUT);
    assign bus.fail_count = r_fail_count;
    assign bus.busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_exit_terminal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_exit_terminal
// Description : Self-checking bench for exit_terminal with a behavioural
//               attempt/lockout model and randomized transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exit_terminal;
    import car_park_pkg::*;

    localparam int MAX  = 3;
    localparam int LOCK = 64;
    localparam int GATE = 8;
    localparam int TOUT = 16;

    logic clk;
    logic gl_reset;
    int   total;
    int   bad;
    int   m_fc;

    exit_terminal_if bus ();

    exit_terminal #(
        .MAX_TRIES   (MAX),
        .LOCK_CYCLES (LOCK),
        .GATE_CYCLES (GATE),
        .TIMEOUT     (TOUT)
    ) dut (
        .enable   (clk),
        .gl_reset (gl_reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: summary not reached in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_data  = k;
        bus.key_valid = 1'b1;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic do_reset;
        gl_reset = 1'b1;
        tick();
        tick();
        gl_reset = 1'b0;
        m_fc = 0;
    endtask

    // One full attempt. kind: 0=ok, 1=fail, 2=ok+fail together, 3=no verdict.
    task automatic run_attempt(input logic [2:0] spot, input logic [7:0] code,
                               input int kind, input int dly);
        int n;
        press({1'b0, spot});
        press(code[7:4]);
        press(code[3:0]);
        total++;
        if (bus.car_exit !== 1'b1 || bus.exit_from !== spot || bus.exit_code !== code) begin
            bad++;
            $display("FAIL request: car_exit=%b from=%0d code=%h, want 1 from=%0d code=%h",
                     bus.car_exit, bus.exit_from, bus.exit_code, spot, code);
        end
        tick();
        total++;
        if (bus.car_exit !== 1'b0) begin
            bad++;
            $display("FAIL request_len: car_exit=%b, want 0", bus.car_exit);
        end
        if (kind == 3) begin
            n = 0;
            while (bus.deny_led !== 1'b1 && n < 4 * TOUT) begin
                tick();
                n++;
            end
            total++;
            if (n != TOUT || bus.timeout !== 1'b1) begin
                bad++;
                $display("FAIL timeout: deny after %0d cycles timeout=%b, want %0d cycles timeout=1",
                         n, bus.timeout, TOUT);
            end
        end else begin
            for (int i = 0; i < dly; i++) begin
                tick();
                total++;
                if (bus.exit_from !== spot || bus.exit_code !== code || bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL hold: from=%0d code=%h busy=%b, want %0d %h 1",
                             bus.exit_from, bus.exit_code, bus.busy, spot, code);
                end
            end
            bus.resp_ok   = (kind != 1);
            bus.resp_fail = (kind != 0);
            tick();
            bus.resp_ok   = 1'b0;
            bus.resp_fail = 1'b0;
        end
        if (kind == 0) begin
            m_fc = 0;
            n = 0;
            while (bus.gate_open === 1'b1 && n < 4 * GATE) begin
                total++;
                if (bus.fail_count !== 3'(m_fc)) begin
                    bad++;
                    $display("FAIL open_count: fail_count=%0d, want %0d", bus.fail_count, m_fc);
                end
                tick();
                n++;
            end
            total++;
            if (n != GATE || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL gate_len: gate cycles=%0d busy=%b, want %0d busy=0", n, bus.busy, GATE);
            end
        end else begin
            m_fc = (m_fc < MAX) ? m_fc + 1 : m_fc;
            total++;
            if (bus.deny_led !== 1'b1 || bus.fail_count !== 3'(m_fc) || bus.timeout !== 1'(kind == 3)) begin
                bad++;
                $display("FAIL deny: deny=%b fail_count=%0d timeout=%b, want 1 %0d %0d",
                         bus.deny_led, bus.fail_count, bus.timeout, m_fc, kind == 3);
            end
            tick();
            if (m_fc == MAX) begin
                n = 0;
                while (bus.locked === 1'b1 && n < 4 * LOCK) begin
                    bus.key_valid = 1'b1;
                    bus.key_data  = 4'($urandom_range(1, 7));
                    tick();
                    n++;
                end
                bus.key_valid = 1'b0;
                m_fc = 0;
                total++;
                if (n != LOCK) begin
                    bad++;
                    $display("FAIL lock_len: locked cycles=%0d, want %0d", n, LOCK);
                end
            end
            total++;
            if (bus.busy !== 1'b0 || bus.deny_led !== 1'b0 || bus.fail_count !== 3'(m_fc)) begin
                bad++;
                $display("FAIL after_deny: busy=%b deny=%b fail_count=%0d, want 0 0 %0d",
                         bus.busy, bus.deny_led, bus.fail_count, m_fc);
            end
        end
    endtask

    task automatic test_reset;
        gl_reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.car_exit, bus.exit_from, bus.exit_code, bus.gate_open, bus.deny_led,
             bus.key_error, bus.timeout, bus.locked, bus.fail_count, bus.busy} !== 21'd0) begin
            bad++;
            $display("FAIL reset: outputs not all zero (from=%0d code=%h fc=%0d busy=%b)",
                     bus.exit_from, bus.exit_code, bus.fail_count, bus.busy);
        end
        gl_reset = 1'b0;
        m_fc = 0;
    endtask

    task automatic test_success;
        do_reset();
        run_attempt(3'd6, pass_code(3'd6), 0, 1);
    endtask

    task automatic test_key_error;
        logic [3:0] keys [3];
        keys[0] = 4'd0;
        keys[1] = 4'd9;
        keys[2] = 4'($urandom_range(8, 15));
        for (int i = 0; i < 3; i++) begin
            press(keys[i]);
            total++;
            if (bus.key_error !== 1'b1 || bus.busy !== 1'b0 || bus.car_exit !== 1'b0) begin
                bad++;
                $display("FAIL key_error: key=%0d err=%b busy=%b car_exit=%b, want 1 0 0",
                         keys[i], bus.key_error, bus.busy, bus.car_exit);
            end
            tick();
            total++;
            if (bus.key_error !== 1'b0) begin
                bad++;
                $display("FAIL key_error_len: err=%b, want 0", bus.key_error);
            end
        end
    endtask

    task automatic test_cancel;
        int seen;
        press(4'd2);
        press(4'd0);
        bus.key_valid  = 1'b1;
        bus.key_data   = 4'd6;
        bus.key_cancel = 1'b1;
        tick();
        bus.key_valid  = 1'b0;
        bus.key_cancel = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.exit_code !== 8'h00 || bus.car_exit !== 1'b0) begin
            bad++;
            $display("FAIL cancel: busy=%b code=%h car_exit=%b, want 0 00 0",
                     bus.busy, bus.exit_code, bus.car_exit);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.car_exit === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL cancel_req: car_exit cycles=%0d, want 0", seen);
        end
        run_attempt(3'd2, pass_code(3'd2), 0, 0);
    endtask

    task automatic test_lockout;
        do_reset();
        for (int i = 0; i < MAX; i++) begin
            run_attempt(3'd4, 8'h99, 1, int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_timeout_both;
        do_reset();
        run_attempt(3'd7, 8'h57, 3, 0);
        run_attempt(3'd3, pass_code(3'd3), 2, 2);
    endtask

    task automatic test_reset_midway;
        for (int s = 0; s < 2; s++) begin
            do_reset();
            if (s == 0) begin
                press(4'd1);
                press(4'd0);
                press(4'd3);
                tick();
                bus.resp_ok = 1'b1;
                tick();
                bus.resp_ok = 1'b0;
                repeat (3) tick();
                total++;
                if (bus.gate_open !== 1'b1) begin
                    bad++;
                    $display("FAIL midway_open: gate_open=%b, want 1", bus.gate_open);
                end
            end else begin
                for (int i = 0; i < MAX - 1; i++) begin
                    run_attempt(3'd4, 8'h99, 1, 0);
                end
                press(4'd4);
                press(4'd9);
                press(4'd9);
                tick();
                bus.resp_fail = 1'b1;
                tick();
                bus.resp_fail = 1'b0;
                repeat (11) tick();
                total++;
                if (bus.locked !== 1'b1) begin
                    bad++;
                    $display("FAIL midway_lock: locked=%b, want 1", bus.locked);
                end
            end
            gl_reset = 1'b1;
            tick();
            gl_reset = 1'b0;
            m_fc = 0;
            total++;
            if ({bus.car_exit, bus.exit_from, bus.exit_code, bus.gate_open, bus.deny_led,
                 bus.key_error, bus.timeout, bus.locked, bus.fail_count, bus.busy} !== 21'd0) begin
                bad++;
                $display("FAIL midway_reset%0d: gate=%b locked=%b fc=%0d busy=%b, want all 0",
                         s, bus.gate_open, bus.locked, bus.fail_count, bus.busy);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] spot;
        logic [7:0] code;
        int         kind;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            spot = 3'($urandom_range(1, 7));
            code = ($urandom_range(0, 1) == 0) ? pass_code(spot) : 8'($urandom);
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                press(4'($urandom_range(8, 15)));
                total++;
                if (bus.key_error !== 1'b1 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_key_error: err=%b busy=%b, want 1 0", bus.key_error, bus.busy);
                end
            end
            run_attempt(spot, code, kind, int'($urandom_range(0, TOUT - 3)));
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        m_fc           = 0;
        gl_reset       = 1'b1;
        bus.key_valid  = 1'b0;
        bus.key_data   = 4'd0;
        bus.key_cancel = 1'b0;
        bus.resp_ok    = 1'b0;
        bus.resp_fail  = 1'b0;
        test_reset();
        test_success();
        test_cancel();
        test_key_error();
        test_lockout();
        test_timeout_both();
        test_reset_midway();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
